// File: rtl/fde_core_param.sv
`default_nettype none
// ============================================================================
// Module  : fde_core_param
// Brief   : Multi-cycle fetch/decode/execute core with register file, flags,
//           fetch handshake with wait states, branches and write-back port.
// Revision: 1.0 - initial release
// ============================================================================
module fde_core_param #(
  parameter int  DATA_W = 8,
  parameter int  PC_W   = 12,
  parameter int  REG_AW = 4,
  localparam int INST_W = 4 + 3 * REG_AW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [INST_W-1:0] i_imem_data,
  output logic [PC_W-1:0]   o_pc,
  output logic [2:0]        o_state,
  output logic              o_halted,
  output logic              o_wb_en,
  output logic [REG_AW-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_flag_z,
  output logic              o_flag_c
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_next_pc;
  logic [INST_W-1:0] r_inst;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_z;
  logic              r_c;
  logic              r_wb_en;
  logic [REG_AW-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;

  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [DATA_W-1:0] w_imm;
  logic [PC_W-1:0]   w_target;
  logic [PC_W-1:0]   w_pc_inc;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_result;
  logic              w_c;
  logic              w_z;
  logic              w_flag_upd;
  logic              w_write;
  logic [PC_W-1:0]   w_next_pc;

  assign w_op     = r_inst[INST_W-1 -: 4];
  assign w_rd     = r_inst[3*REG_AW-1 -: REG_AW];
  assign w_rs1    = r_inst[2*REG_AW-1 -: REG_AW];
  assign w_rs2    = r_inst[REG_AW-1:0];
  // Immediate and jump target are raw instruction fields resized to the datapath / pc.
  assign w_imm    = DATA_W'(r_inst[2*REG_AW-1:0]);
  assign w_target = PC_W'(r_inst[3*REG_AW-1:0]);
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff   = {1'b0, r_a} - {1'b0, r_b};
  assign w_z      = (w_result == '0);

  always_comb begin
    w_result   = '0;
    w_c        = r_c;
    w_flag_upd = 1'b0;
    w_write    = 1'b0;
    w_next_pc  = w_pc_inc;
    case (w_op)
      OP_ADD: begin w_result = w_sum[DATA_W-1:0];  w_c = w_sum[DATA_W];  w_flag_upd = 1'b1; w_write = 1'b1; end
      OP_SUB: begin w_result = w_diff[DATA_W-1:0]; w_c = w_diff[DATA_W]; w_flag_upd = 1'b1; w_write = 1'b1; end
      OP_AND: begin w_result = r_a & r_b; w_c = 1'b0; w_flag_upd = 1'b1; w_write = 1'b1; end
      OP_OR:  begin w_result = r_a | r_b; w_c = 1'b0; w_flag_upd = 1'b1; w_write = 1'b1; end
      OP_XOR: begin w_result = r_a ^ r_b; w_c = 1'b0; w_flag_upd = 1'b1; w_write = 1'b1; end
      OP_NOT: begin w_result = ~r_a;      w_c = 1'b0; w_flag_upd = 1'b1; w_write = 1'b1; end
      OP_SHL: begin w_result = {r_a[DATA_W-2:0], 1'b0}; w_c = r_a[DATA_W-1]; w_flag_upd = 1'b1; w_write = 1'b1; end
      OP_SHR: begin w_result = {1'b0, r_a[DATA_W-1:1]}; w_c = r_a[0];        w_flag_upd = 1'b1; w_write = 1'b1; end
      OP_LDI: begin w_result = w_imm; w_write = 1'b1; end
      OP_MOV: begin w_result = r_a;   w_write = 1'b1; end
      OP_JMP: w_next_pc = w_target;
      OP_BZ:  if (r_z) w_next_pc = w_target;
      // Compare keeps the difference only long enough to derive the flags.
      OP_CMP: begin w_result = w_diff[DATA_W-1:0]; w_c = w_diff[DATA_W]; w_flag_upd = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_next_pc <= '0;
      r_inst    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_run) r_state <= S_FETCH;
        S_FETCH: begin
          if (i_imem_valid) begin
            r_inst  <= i_imem_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_regs[w_rs1];
          r_b     <= r_regs[w_rs2];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_flag_upd) begin
            r_z <= w_z;
            r_c <= w_c;
          end
          r_next_pc <= w_next_pc;
          r_wb_en   <= w_write;
          // Observation port keeps its last value across non-writing instructions.
          if (w_write) begin
            r_wb_addr <= w_rd;
            r_wb_data <= w_result;
          end
          r_state <= (w_op == OP_HALT) ? S_HALT : S_WB;
        end
        S_WB: begin
          if (r_wb_en) r_regs[r_wb_addr] <= r_wb_data;
          r_wb_en <= 1'b0;
          r_pc    <= r_next_pc;
          r_state <= i_run ? S_FETCH : S_IDLE;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_imem_req  = (r_state == S_FETCH);
  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_state     = r_state;
  assign o_halted    = (r_state == S_HALT);
  assign o_wb_en     = r_wb_en;
  assign o_wb_addr   = r_wb_addr;
  assign o_wb_data   = r_wb_data;
  assign o_flag_z    = r_z;
  assign o_flag_c    = r_c;

endmodule
`default_nettype wire

// File: tb/tb_fde_core_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_fde_core_param
// Brief   : Directed self-checking bench for fde_core_param at default sizes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fde_core_param;

  logic        i_clk;
  logic        i_reset;
  logic        i_run;
  logic        o_imem_req;
  logic [11:0] o_imem_addr;
  logic        i_imem_valid;
  logic [15:0] i_imem_data;
  logic [11:0] o_pc;
  logic [2:0]  o_state;
  logic        o_halted;
  logic        o_wb_en;
  logic [3:0]  o_wb_addr;
  logic [7:0]  o_wb_data;
  logic        o_flag_z;
  logic        o_flag_c;

  logic [15:0] imem [4096];
  int          mem_wait;
  int          wcnt;
  int          checks;
  int          errors;

  fde_core_param #(.DATA_W(8), .PC_W(12), .REG_AW(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_valid(i_imem_valid), .i_imem_data(i_imem_data),
    .o_pc(o_pc), .o_state(o_state), .o_halted(o_halted),
    .o_wb_en(o_wb_en), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .o_flag_z(o_flag_z), .o_flag_c(o_flag_c)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memory answers after mem_wait request cycles.
  always @(posedge i_clk) begin
    if (!o_imem_req) wcnt <= 0;
    else             wcnt <= wcnt + 1;
  end
  assign i_imem_valid = o_imem_req && (wcnt >= mem_wait);
  assign i_imem_data  = imem[o_imem_addr];

  // Runs from the current negedge until the next instruction boundary.
  task automatic exec_one(output int cyc, output logic wb, output logic [3:0] wa, output logic [7:0] wd);
    logic seen;
    bit   done;
    cyc = 0; wb = 1'b0; wa = '0; wd = '0; seen = 1'b0; done = 1'b0;
    while (!done && cyc < 60) begin
      if (o_wb_en) begin wb = 1'b1; wa = o_wb_addr; wd = o_wb_data; end
      if (o_state != 3'd1) seen = 1'b1;
      @(negedge i_clk);
      cyc++;
      if (seen && (o_state == 3'd0 || o_state == 3'd1 || o_state == 3'd5)) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_run = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_state, o_pc, o_imem_addr, o_imem_req, o_halted, o_wb_en, o_wb_addr, o_wb_data, o_flag_z, o_flag_c} !== '0) begin
      errors++; $display("FAIL reset_outputs got st=%0h pc=%0h req=%0b wb=%0b/%0h/%0h z=%0b c=%0b expected all 0",
                         o_state, o_pc, o_imem_req, o_wb_en, o_wb_addr, o_wb_data, o_flag_z, o_flag_c);
    end
    i_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_state !== 3'd0 || o_pc !== 12'h000 || o_imem_req !== 1'b0 || o_wb_en !== 1'b0) begin
        errors++; $display("FAIL idle_hold cyc %0d got st=%0h pc=%0h req=%0b wb=%0b expected 0 0 0 0", i, o_state, o_pc, o_imem_req, o_wb_en);
      end
    end
  endtask

  task automatic test_alu();
    int cyc; logic wb; logic [3:0] wa; logic [7:0] wd;
    i_run = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_state !== 3'd1 || o_imem_req !== 1'b1 || o_imem_addr !== 12'h000) begin
      errors++; $display("FAIL first_fetch got st=%0h req=%0b addr=%0h expected 1 1 0", o_state, o_imem_req, o_imem_addr);
    end
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (cyc !== 4 || wb !== 1'b1 || wa !== 4'd1 || wd !== 8'hFF) begin
      errors++; $display("FAIL ldi_r1 got cyc=%0d wb=%0b rd=%0h data=%0h expected 4 1 1 ff", cyc, wb, wa, wd);
    end
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (cyc !== 4 || wb !== 1'b1 || wa !== 4'd2 || wd !== 8'h01) begin
      errors++; $display("FAIL ldi_r2 got cyc=%0d wb=%0b rd=%0h data=%0h expected 4 1 2 01", cyc, wb, wa, wd);
    end
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (cyc !== 4 || wb !== 1'b1 || wa !== 4'd3 || wd !== 8'h00 || o_flag_z !== 1'b1 || o_flag_c !== 1'b1 || o_pc !== 12'h003) begin
      errors++; $display("FAIL add_wrap got cyc=%0d wb=%0b rd=%0h data=%0h z=%0b c=%0b pc=%0h expected 4 1 3 00 1 1 003",
                         cyc, wb, wa, wd, o_flag_z, o_flag_c, o_pc);
    end
  endtask

  task automatic test_branch();
    int cyc; logic wb; logic [3:0] wa; logic [7:0] wd;
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (wb !== 1'b1 || wa !== 4'd4 || wd !== 8'h02 || o_flag_z !== 1'b0 || o_flag_c !== 1'b1) begin
      errors++; $display("FAIL sub_borrow got wb=%0b rd=%0h data=%0h z=%0b c=%0b expected 1 4 02 0 1", wb, wa, wd, o_flag_z, o_flag_c);
    end
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (wb !== 1'b0 || o_flag_z !== 1'b1 || o_flag_c !== 1'b0 || o_wb_addr !== 4'd4 || o_wb_data !== 8'h02) begin
      errors++; $display("FAIL cmp_eq got wb=%0b z=%0b c=%0b hold=%0h/%0h expected 0 1 0 4/02", wb, o_flag_z, o_flag_c, o_wb_addr, o_wb_data);
    end
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (wb !== 1'b0 || o_pc !== 12'h010) begin
      errors++; $display("FAIL bz_taken got wb=%0b pc=%0h expected 0 010", wb, o_pc);
    end
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (wd !== 8'hFE || wa !== 4'd5 || o_flag_z !== 1'b0 || o_flag_c !== 1'b1) begin
      errors++; $display("FAIL add_carry got rd=%0h data=%0h z=%0b c=%0b expected 5 fe 0 1", wa, wd, o_flag_z, o_flag_c);
    end
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (wb !== 1'b0 || o_pc !== 12'h012) begin
      errors++; $display("FAIL bz_fallthrough got wb=%0b pc=%0h expected 0 012", wb, o_pc);
    end
  endtask

  task automatic test_mem_wait();
    int cyc; logic wb; logic [3:0] wa; logic [7:0] wd;
    mem_wait = 3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_state !== 3'd1 || o_imem_req !== 1'b1 || o_imem_addr !== 12'h012) begin
        errors++; $display("FAIL wait_hold cyc %0d got st=%0h req=%0b addr=%0h expected 1 1 012", i, o_state, o_imem_req, o_imem_addr);
      end
      @(negedge i_clk);
    end
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (cyc + 4 !== 7 || wb !== 1'b1 || wa !== 4'd6 || wd !== 8'hFE) begin
      errors++; $display("FAIL wait_instr got cyc=%0d rd=%0h data=%0h expected 7 6 fe", cyc + 4, wa, wd);
    end
    mem_wait = 0;
  endtask

  task automatic test_run_drop();
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_state !== 3'd3) begin
      errors++; $display("FAIL run_drop_exec got st=%0h expected 3", o_state);
    end
    i_run = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_state !== 3'd4 || o_wb_en !== 1'b1 || o_wb_addr !== 4'd7 || o_wb_data !== 8'hFE) begin
      errors++; $display("FAIL run_drop_wb got st=%0h wb=%0b rd=%0h data=%0h expected 4 1 7 fe", o_state, o_wb_en, o_wb_addr, o_wb_data);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_state !== 3'd0 || o_imem_req !== 1'b0 || o_pc !== 12'h014) begin
        errors++; $display("FAIL run_drop_idle cyc %0d got st=%0h req=%0b pc=%0h expected 0 0 014", i, o_state, o_imem_req, o_pc);
      end
    end
    i_run = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_state !== 3'd1 || o_imem_addr !== 12'h014) begin
      errors++; $display("FAIL resume got st=%0h addr=%0h expected 1 014", o_state, o_imem_addr);
    end
  endtask

  task automatic test_wrap();
    int cyc; logic wb; logic [3:0] wa; logic [7:0] wd;
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (cyc !== 4 || wb !== 1'b0 || o_pc !== 12'hFFF) begin
      errors++; $display("FAIL jmp got cyc=%0d wb=%0b pc=%0h expected 4 0 fff", cyc, wb, o_pc);
    end
    imem[0] = 16'hF000;
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (wb !== 1'b0 || o_pc !== 12'h000) begin
      errors++; $display("FAIL pc_wrap got wb=%0b pc=%0h expected 0 000", wb, o_pc);
    end
  endtask

  task automatic test_halt();
    int cyc; logic wb; logic [3:0] wa; logic [7:0] wd;
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (cyc !== 3 || wb !== 1'b0 || o_state !== 3'd5 || o_halted !== 1'b1) begin
      errors++; $display("FAIL halt_enter got cyc=%0d wb=%0b st=%0h halted=%0b expected 3 0 5 1", cyc, wb, o_state, o_halted);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_state !== 3'd5 || o_halted !== 1'b1 || o_imem_req !== 1'b0 || o_pc !== 12'h000) begin
        errors++; $display("FAIL halt_hold cyc %0d got st=%0h halted=%0b req=%0b pc=%0h expected 5 1 0 000", i, o_state, o_halted, o_imem_req, o_pc);
      end
    end
  endtask

  task automatic test_async_reset();
    int cyc; logic wb; logic [3:0] wa; logic [7:0] wd;
    i_reset = 1'b0;
    #1;
    checks++;
    if ({o_state, o_pc, o_imem_req, o_halted, o_wb_en, o_wb_addr, o_wb_data, o_flag_z, o_flag_c} !== '0) begin
      errors++; $display("FAIL reset_from_halt got st=%0h pc=%0h halted=%0b wb=%0b/%0h/%0h z=%0b c=%0b expected all 0",
                         o_state, o_pc, o_halted, o_wb_en, o_wb_addr, o_wb_data, o_flag_z, o_flag_c);
    end
    @(negedge i_clk);
    imem[0]  = 16'h1312;
    mem_wait = 5;
    i_reset  = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_state !== 3'd1 || o_imem_req !== 1'b1) begin
      errors++; $display("FAIL pre_reset_fetch got st=%0h req=%0b expected 1 1", o_state, o_imem_req);
    end
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if (o_state !== 3'd0 || o_imem_req !== 1'b0 || o_imem_addr !== 12'h000 || o_wb_en !== 1'b0) begin
      errors++; $display("FAIL reset_mid_fetch got st=%0h req=%0b addr=%0h wb=%0b expected 0 0 000 0", o_state, o_imem_req, o_imem_addr, o_wb_en);
    end
    @(negedge i_clk);
    mem_wait = 0;
    i_reset  = 1'b1;
    @(negedge i_clk);
    exec_one(cyc, wb, wa, wd);
    checks++;
    if (cyc !== 4 || wb !== 1'b1 || wa !== 4'd3 || wd !== 8'h00 || o_flag_z !== 1'b1 || o_flag_c !== 1'b0) begin
      errors++; $display("FAIL regs_cleared got cyc=%0d wb=%0b rd=%0h data=%0h z=%0b c=%0b expected 4 1 3 00 1 0",
                         cyc, wb, wa, wd, o_flag_z, o_flag_c);
    end
  endtask

  initial begin
    checks = 0; errors = 0; mem_wait = 0;
    i_reset = 1'b0; i_run = 1'b0;
    for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
    imem[12'h000] = 16'h91FF;  // LDI R1,ff
    imem[12'h001] = 16'h9201;  // LDI R2,01
    imem[12'h002] = 16'h1312;  // ADD R3,R1,R2
    imem[12'h003] = 16'h2421;  // SUB R4,R2,R1
    imem[12'h004] = 16'hD022;  // CMP R2,R2
    imem[12'h005] = 16'hC010;  // BZ 010
    imem[12'h010] = 16'h1511;  // ADD R5,R1,R1
    imem[12'h011] = 16'hC030;  // BZ 030 (not taken)
    imem[12'h012] = 16'h6620;  // NOT R6,R2
    imem[12'h013] = 16'h5712;  // XOR R7,R1,R2
    imem[12'h014] = 16'hBFFF;  // JMP fff
    imem[12'hFFF] = 16'h0000;  // NOP
    test_reset();
    test_alu();
    test_branch();
    test_mem_wait();
    test_run_drop();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fde_core_param.md
Name: fde_core_param

Overview:
- Parametrised multi-cycle fetch/decode/execute CPU core. Successor to the fixed 8-bit, 16-register FDE top.
- Adds an internal register file, a memory fetch handshake with wait states, a run/halt control FSM, Z/C flags, jumps/branches and a write-back observation port.
- Sits between the instruction memory and the system controller.

Parameters:
- DATA_W, 8, datapath and register width (>=2).
- PC_W, 12, program counter width.
- REG_AW, 4, register address width; 2**REG_AW registers. Instruction width INST_W = 4+3*REG_AW (local, 16 at defaults).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_run  in  1  level; core fetches new instructions while high.
- o_imem_req  out  1  fetch request, high throughout FETCH.
- o_imem_addr  out  PC_W  fetch address (= pc).
- i_imem_valid  in  1  instruction data valid; sampled only in FETCH.
- i_imem_data  in  INST_W  instruction word.
- o_pc  out  PC_W  current program counter.
- o_state  out  3  FSM state encoding.
- o_halted  out  1  high in HALT state.
- o_wb_en  out  1  one-cycle register write strobe.
- o_wb_addr  out  REG_AW  destination register.
- o_wb_data  out  DATA_W  written value.
- o_flag_z  out  1  zero flag.
- o_flag_c  out  1  carry/borrow flag.

Behaviour:
- Reset, asynchronous and active-low:
  - state=IDLE(0), pc=0, all registers=0, flags=0, latched instruction=0.
  - All outputs 0, except o_state=0 and o_imem_addr=0.
- Instruction fields: [INST_W-1 -: 4] opcode, then rd, rs1, rs2 (REG_AW each, MSB to LSB).
- FSM states: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
- IDLE: go to FETCH when i_run=1.
- FETCH:
  - o_imem_req=1, o_imem_addr=pc.
  - On i_imem_valid=1 (may be the first FETCH cycle), latch i_imem_data and go to DECODE.
  - Otherwise hold; the wait is unbounded.
- DECODE: register operands A=R[rs1], B=R[rs2] into operand regs; go to EXEC.
- EXEC: compute result, flags and next pc. Go to HALT for opcode F, else go to WB.
- WB:
  - For writing opcodes, pulse o_wb_en=1 with o_wb_addr=rd and o_wb_data=result; R[rd] is updated at the same edge.
  - pc <= next pc.
  - Go to FETCH if i_run=1, else IDLE.
  - o_wb_addr/o_wb_data hold their last values when o_wb_en=0.
- Timing: minimum 4 cycles per instruction (FETCH/DECODE/EXEC/WB), plus memory wait cycles.
- Opcodes (results truncated to DATA_W; Z = (result==0)):
  - 0 NOP.
  - 1 ADD rd=A+B; C=carry out.
  - 2 SUB rd=A-B; C=borrow (A<B).
  - 3 AND, 4 OR, 5 XOR; C=0.
  - 6 NOT rd=~A; C=0.
  - 7 SHL rd=A<<1; C=A[MSB].
  - 8 SHR rd=A>>1 (logical); C=A[0].
  - 9 LDI rd={rs1,rs2} zero-extended/truncated to DATA_W; flags unchanged.
  - A MOV rd=A; flags unchanged.
  - B JMP: next pc={rd,rs1,rs2} zero-extended/truncated to PC_W.
  - C BZ: if Z=1 at EXEC, next pc=jump target, else pc+1.
  - D CMP: flags as SUB, no write.
  - E reserved: behaves as NOP.
  - F HALT.
- Writing opcodes: 1–A. Flags update at EXEC only for opcodes 1–8 and D.
- Default next pc = pc+1 modulo 2**PC_W; 2**PC_W-1 wraps to 0.
- Same-register source and destination (rd=rs1=rs2) is legal; operands are already latched, so no hazard.
- i_run falling mid-instruction: the instruction completes through WB, then the core goes to IDLE. pc points to the next instruction and the core resumes there when i_run rises.
- HALT: pc is not advanced, o_halted=1, o_imem_req=0. Only reset exits HALT; i_run is ignored.
- i_imem_valid outside FETCH: ignored.
- Reset asserted mid-operation: immediate return to the reset state; no partial write-back.

Test Plan:
- Reset/idle: i_reset=0, then 1 with i_run=0 for 10 cycles -> o_state=0, o_pc=0, o_imem_req=0, o_wb_en=0 throughout.
- ALU sequence, zero-wait memory: LDI R1,0xFF; LDI R2,0x01; ADD R3,R1,R2 -> wb R3=0x00, Z=1, C=1. Each instruction takes exactly 4 cycles; o_pc ends at 3.
- Flags and branch: SUB R4,R2,R1 (1-255) -> R4=0x02, C=1, Z=0. Then CMP R2,R2 -> Z=1, no o_wb_en. Then BZ 0x010 -> o_pc=0x010. With Z=0, BZ falls through to pc+1.
- Memory wait: i_imem_valid delayed 3 cycles -> o_imem_req and o_imem_addr held stable, state stays 1, instruction takes 7 cycles.
- Run/halt: drop i_run during EXEC -> WB completes, then IDLE. Re-raise i_run -> fetch at the following pc. HALT -> o_halted=1 with i_run high for 20 cycles. Async reset mid-FETCH -> all outputs 0 within the same cycle.
- PC wrap: JMP 0xFFF then NOP -> o_pc=0x000.
